// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiplier sequencer.
// The MAC output register adds one cycle between en_MAC_out and a valid y.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        READ,
        DRAIN,
        OUTLD,
        CAPT,
        HOLD
    } state_t;

    localparam int MAC_OUT_LAT = 1;

    // Four worst-case products fit without overflow.
    function automatic int resW(input int inW);
        return 2 * inW + 2;
    endfunction

endpackage

// File: rtl/en_delay_line.sv
// Delays the memory read enable by RD_LAT cycles so that en_MAC lines up with valid doutb.
module en_delay_line #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic en_o
);

    logic [RD_LAT-1:0] pipe_q;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) pipe_q <= '0;
                else     pipe_q <= en_i;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) pipe_q <= '0;
                else     pipe_q <= {pipe_q[RD_LAT-2:0], en_i};
            end
        end
    endgenerate

    assign en_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for matrix_multiplier: loads one row/column pair of vectors,
// streams them through the MAC and hands back the dot product.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int In_W       = 8,
    parameter int In_D_Add_W = 4,
    parameter int In_Items   = 6,
    parameter int RD_LAT     = 1,
    localparam int RES_W     = resW(In_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [In_W-1:0] in_row,
    input  logic signed [In_W-1:0] in_col,
    output logic                   ena_r,
    output logic                   ena_c,
    output logic                   wea_r,
    output logic                   wea_c,
    output logic [In_D_Add_W-1:0]  addra_r,
    output logic [In_D_Add_W-1:0]  addra_c,
    output logic signed [In_W-1:0] din_r,
    output logic signed [In_W-1:0] din_c,
    output logic                   enb_r,
    output logic                   enb_c,
    output logic [In_D_Add_W-1:0]  addrb_r,
    output logic [In_D_Add_W-1:0]  addrb_c,
    output logic                   clr,
    output logic                   en_MAC,
    output logic                   en_MAC_out,
    input  logic signed [RES_W-1:0] y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [RES_W-1:0] result,
    output logic                   busy
);

    localparam logic [In_D_Add_W-1:0] LastAddr  = In_D_Add_W'(In_Items - 1);
    localparam logic [7:0]            DrainLast = 8'(RD_LAT - 1);
    localparam logic [7:0]            CaptLast  = 8'(MAC_OUT_LAT - 1);

    state_t                   state_q, state_d;
    logic [In_D_Add_W-1:0]    wrAddr_q, wrAddr_d;
    logic [In_D_Add_W-1:0]    rdAddr_q, rdAddr_d;
    logic [7:0]               phaseCnt_q, phaseCnt_d;
    logic signed [RES_W-1:0]  result_q, result_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wrAddr_q   <= '0;
            rdAddr_q   <= '0;
            phaseCnt_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            wrAddr_q   <= wrAddr_d;
            rdAddr_q   <= rdAddr_d;
            phaseCnt_q <= phaseCnt_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wrAddr_d   = wrAddr_q;
        rdAddr_d   = rdAddr_q;
        phaseCnt_d = phaseCnt_q;
        result_d   = result_q;
        in_ready   = 1'b0;
        ena_r      = 1'b0;
        ena_c      = 1'b0;
        wea_r      = 1'b0;
        wea_c      = 1'b0;
        addra_r    = '0;
        addra_c    = '0;
        din_r      = '0;
        din_c      = '0;
        enb_r      = 1'b0;
        enb_c      = 1'b0;
        addrb_r    = '0;
        addrb_c    = '0;
        clr        = 1'b0;
        en_MAC_out = 1'b0;
        res_valid  = 1'b0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                clr      = 1'b1;
                wrAddr_d = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ena_r    = 1'b1;
                    ena_c    = 1'b1;
                    wea_r    = 1'b1;
                    wea_c    = 1'b1;
                    addra_r  = wrAddr_q;
                    addra_c  = wrAddr_q;
                    din_r    = in_row;
                    din_c    = in_col;
                    wrAddr_d = wrAddr_q + 1'b1;
                    if (wrAddr_q == LastAddr) begin
                        rdAddr_d = '0;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                enb_r    = 1'b1;
                enb_c    = 1'b1;
                addrb_r  = rdAddr_q;
                addrb_c  = rdAddr_q;
                rdAddr_d = rdAddr_q + 1'b1;
                if (rdAddr_q == LastAddr) begin
                    phaseCnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            // Wait for the last read to leave the enable delay line.
            DRAIN: begin
                if (phaseCnt_q == DrainLast) begin
                    phaseCnt_d = '0;
                    state_d    = OUTLD;
                end else begin
                    phaseCnt_d = phaseCnt_q + 8'd1;
                end
            end
            OUTLD: begin
                en_MAC_out = 1'b1;
                state_d    = CAPT;
            end
            CAPT: begin
                if (phaseCnt_q == CaptLast) begin
                    result_d = y;
                    state_d  = HOLD;
                end else begin
                    phaseCnt_d = phaseCnt_q + 8'd1;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    en_delay_line #(
        .RD_LAT(RD_LAT)
    ) u_enDelay (
        .clk (clk),
        .rst (rst),
        .en_i(enb_r),
        .en_o(en_MAC)
    );

    assign result = result_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a behavioural stand-in for the
// matrix_multiplier memories (read latency 1) and MAC; results go through a scoreboard.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    localparam int InW   = 8;
    localparam int AddW  = 4;
    localparam int Items = 6;
    localparam int RdLat = 1;
    localparam int ResW  = 2 * InW + 2;

    logic clk = 1'b0;
    logic rst, start, inValid, resReady;
    logic signed [InW-1:0] inRow, inCol;
    logic inReady, enaR, enaC, weaR, weaC, enbR, enbC;
    logic [AddW-1:0] addraR, addraC, addrbR, addrbC;
    logic signed [InW-1:0] dinR, dinC;
    logic clr, enMac, enMacOut, resValid, busy;
    logic signed [ResW-1:0] y, result;
    logic [61:0] allOut;

    int checks = 0;
    int errors = 0;
    int clrCount = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int wrLog[$];
    logic signed [ResW-1:0] scoreboard[$];
    logic signed [ResW-1:0] lastExp;
    logic signed [InW-1:0] rowVals[Items];
    logic signed [InW-1:0] colVals[Items];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_seq_ctrl #(
        .In_W(InW), .In_D_Add_W(AddW), .In_Items(Items), .RD_LAT(RdLat)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(inValid), .in_ready(inReady), .in_row(inRow), .in_col(inCol),
        .ena_r(enaR), .ena_c(enaC), .wea_r(weaR), .wea_c(weaC),
        .addra_r(addraR), .addra_c(addraC), .din_r(dinR), .din_c(dinC),
        .enb_r(enbR), .enb_c(enbC), .addrb_r(addrbR), .addrb_c(addrbC),
        .clr(clr), .en_MAC(enMac), .en_MAC_out(enMacOut), .y(y),
        .res_valid(resValid), .res_ready(resReady), .result(result), .busy(busy)
    );

    assign allOut = {inReady, enaR, enaC, weaR, weaC, addraR, addraC, dinR, dinC,
                     enbR, enbC, addrbR, addrbC, clr, enMac, enMacOut, resValid, result, busy};

    // Behavioural memories and MAC standing in for matrix_multiplier.
    logic signed [InW-1:0]  memR[16];
    logic signed [InW-1:0]  memC[16];
    logic signed [InW-1:0]  doutR, doutC;
    logic signed [ResW-1:0] acc, yReg;

    always @(posedge clk) begin
        if (enaR && weaR) memR[addraR] <= dinR;
        if (enaC && weaC) memC[addraC] <= dinC;
        if (enbR) doutR <= memR[addrbR];
        if (enbC) doutC <= memC[addrbC];
        if (clr) acc <= '0;
        else if (enMac) acc <= acc + doutR * doutC;
        if (enMacOut) yReg <= acc;
    end
    assign y = yReg;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Write-port monitor: writes happen exactly on accepted beats with the beat's data.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("wr_en_on_accept", {enaR, enaC, weaR, weaC}, {4{inValid && inReady}});
            if (enaR) begin
                wrLog.push_back(int'(addraR));
                checkOutput("wr_data", {dinR, dinC, addraC}, {inRow, inCol, addraR});
            end
            if (clr) clrCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startJob();
        int clrBefore = clrCount;
        wrLog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("clr_pulse", clr, 1);
        tick();
        checkOutput("clr_once", clrCount - clrBefore, 1);
        checkOutput("clr_before_write", wrLog.size(), 0);
    endtask

    task automatic applyStimulus(input int validPct);
        logic signed [ResW-1:0] expSum = '0;
        int k = 0;
        int guard = 0;
        logic accepted;
        for (int i = 0; i < Items; i++) expSum = expSum + rowVals[i] * colVals[i];
        scoreboard.push_back(expSum);
        while (k < Items && guard < 500) begin
            inValid = ($urandom_range(0, 99) < validPct);
            inRow = inValid ? rowVals[k] : 8'($urandom);
            inCol = inValid ? colVals[k] : 8'($urandom);
            accepted = inValid && inReady;
            if (accepted) acceptCyc = cyc;
            tick();
            if (accepted) k++;
            guard++;
        end
        inValid = 1'b0;
        checkOutput("beats_accepted", k, Items);
    endtask

    task automatic waitResult(input string tag);
        int guard = 0;
        while (!resValid && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_latency"}, cyc - acceptCyc, Items + RdLat + 3);
        if (scoreboard.size() > 0) begin
            lastExp = scoreboard.pop_front();
            checkOutput({tag, "_result"}, result, lastExp);
        end else begin
            checkOutput({tag, "_scoreboard"}, scoreboard.size(), 1);
        end
    endtask

    task automatic checkWriteOrder(input string tag);
        checkOutput({tag, "_wr_count"}, wrLog.size(), Items);
        for (int i = 0; i < wrLog.size() && i < Items; i++)
            checkOutput({tag, "_wr_addr"}, wrLog[i], i);
    endtask

    task automatic holdResult(input int cycles, input bit pokeStart);
        int clrBefore = clrCount;
        resReady = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            start = pokeStart && (i == 5);
            checkOutput("hold_stable", {resValid, busy, result}, {2'b11, lastExp});
            tick();
        end
        start = 1'b0;
        checkOutput("hold_no_clr", clrCount - clrBefore, 0);
    endtask

    task automatic releaseResult(input bit withStart);
        resReady = 1'b1;
        start = withStart;
        tick();
        resReady = 1'b0;
        start = 1'b0;
        checkOutput("release_idle", {resValid, busy}, 0);
        if (withStart) begin
            tick();
            checkOutput("start_ignored", {busy, clr}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; inValid = 1'b0; resReady = 1'b0;
        inRow = '0; inCol = '0;
        repeat (3) tick();
        checkOutput("reset_outputs", allOut, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_outputs", allOut, 0);

        $display("[TB] basic job");
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = 8'(i + 1);
            colVals[i] = 8'(i + 1);
        end
        startJob();
        applyStimulus(100);
        waitResult("basic");
        checkOutput("basic_const", result, 91);
        checkWriteOrder("basic");
        holdResult(3, 1'b0);
        releaseResult(1'b0);

        $display("[TB] signed extremes, back-to-back");
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = -8'sd128;
            colVals[i] = -8'sd128;
        end
        startJob();
        applyStimulus(100);
        waitResult("neg_neg");
        checkOutput("neg_neg_const", result, 98304);
        releaseResult(1'b0);
        for (int i = 0; i < Items; i++) colVals[i] = 8'sd127;
        startJob();
        applyStimulus(100);
        waitResult("neg_pos");
        checkOutput("neg_pos_const", result, -97536);
        releaseResult(1'b0);

        $display("[TB] gaps and result hold");
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = 8'sd2;
            colVals[i] = -8'sd3;
        end
        startJob();
        applyStimulus(50);
        guard = 0;
        waitResult("gaps");
        checkOutput("gaps_const", result, -36);
        checkWriteOrder("gaps");
        holdResult(20, 1'b1);
        releaseResult(1'b1);

        $display("[TB] reset mid-job");
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = 8'sd7;
            colVals[i] = 8'sd5;
        end
        startJob();
        applyStimulus(100);
        scoreboard.delete();
        guard = 0;
        while (!(enbR && addrbR == 4'd3) && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("reached_read_j3", {enbR, addrbR}, {1'b1, 4'd3});
        rst = 1'b1;
        tick();
        checkOutput("midjob_reset_outputs", allOut, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = 8'sd1;
            colVals[i] = 8'sd1;
        end
        startJob();
        applyStimulus(100);
        waitResult("after_reset");
        checkOutput("after_reset_const", result, 6);
        releaseResult(1'b0);

        $display("[TB] back-to-back mixed job");
        for (int i = 0; i < Items; i++) begin
            rowVals[i] = 8'(3 * i - 7);
            colVals[i] = 8'(11 - 4 * i);
        end
        startJob();
        applyStimulus(100);
        waitResult("mixed");
        releaseResult(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that drives the matrix_multiplier datapath for one dot product per job.
- Accepts a valid/ready stream of (row, col) element pairs and writes them into the ROW/COLUMN memories through their write ports (port A).
- Reads the memories back through port B, generates clr/en_MAC/en_MAC_out for the MAC, captures y, and returns the result on a valid/ready handshake.
- Sits between the host/load logic and matrix_multiplier; it is the initiator for every control port that matrix_multiplier exposes.

Parameters:
- In_W, 8, signed element width.
- In_D_Add_W, 4, memory address width.
- In_Items, 6, elements per dot product; legal range 1..2**In_D_Add_W.
- RD_LAT, 1, memory read latency in cycles, from enb/addrb to valid doutb.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when in_valid & in_ready
- in_row  in  In_W  signed row element
- in_col  in  In_W  signed column element
- ena_r, ena_c, wea_r, wea_c  out  1 each  memory write-port enables
- addra_r, addra_c  out  In_D_Add_W  write addresses
- din_r, din_c  out  In_W  write data
- enb_r, enb_c  out  1 each  memory read enables
- addrb_r, addrb_c  out  In_D_Add_W  read addresses
- clr  out  1  MAC accumulator clear
- en_MAC  out  1  MAC accumulate enable
- en_MAC_out  out  1  MAC output register load
- y  in  2*In_W+2  signed MAC result; valid 1 cycle after en_MAC_out
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- result  out  2*In_W+2  signed captured dot product
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high) has priority over everything: state IDLE, all outputs 0, counters 0. Reset mid-job abandons the job. Memory contents are not cleared.
- FSM states: IDLE, CLR, LOAD, READ, DRAIN, OUTLD, CAPT, HOLD.
- IDLE: in_ready=0. start=1 -> CLR.
- CLR: clr=1 for exactly 1 cycle -> LOAD.
- LOAD:
  - in_ready=1.
  - On each accepted beat k (0..In_Items-1), in the same cycle: ena_r=ena_c=wea_r=wea_c=1, addra_*=k, din_r=in_row, din_c=in_col.
  - No accepted beat -> write enables 0 and k holds. Gaps in in_valid of any length are legal.
  - Beat k=In_Items-1 accepted -> READ.
- READ: exactly In_Items cycles. enb_r=enb_c=1, addrb_*=j, j=0..In_Items-1 incrementing every cycle -> DRAIN.
- en_MAC is enb delayed by exactly RD_LAT cycles through a shift register. en_MAC is therefore high for exactly In_Items cycles, aligned with valid doutb.
- DRAIN: RD_LAT cycles, until the delayed enable empties -> OUTLD.
- OUTLD: en_MAC_out=1 for 1 cycle -> CAPT.
- CAPT: result<=y on this edge -> HOLD.
- HOLD: res_valid=1 and result stable. res_ready=1 -> IDLE, res_valid drops the next cycle.
- Latency: res_valid rises exactly In_Items+RD_LAT+3 cycles after the edge that accepts the last beat.
- start outside IDLE is ignored. start and res_ready together in HOLD -> go to IDLE only; a new start is needed.
- Address counters never wrap within a job. Both counters reset to 0 on entering LOAD and READ respectively.
- Write and read phases never overlap, so no read/write collision is possible.
- Arithmetic is done in the MAC: a result of width 2*In_W+2 holds up to 4 worst-case products without overflow. In_Items>4 with full-scale operands may wrap; that is accepted, not flagged.

Decomposition:
- Package matmul_pkg: state encoding, RES_W = 2*In_W+2 width function, MAC output latency constant (1).
- One sub-module, en_delay_line (parameter RD_LAT, synchronous reset), generates en_MAC from enb.

Test Plan:
- Bench pairs the DUT with matrix_multiplier, memory read latency 1.
- Basic: start; row = col = 1,2,3,4,5,6 streamed back-to-back -> result = 91; res_valid exactly 10 cycles after the last beat; clr pulsed once, before the first write.
- Signed extremes: row = col = -128 (x6) -> result = 98304. Then row = -128, col = 127 (x6) -> result = -97536.
- Backpressure and gaps: in_valid random 50% with row = 2, col = -3 -> result = -36. Writes occur only on accepted beats; addra_* values are 0..5 in order.
- Result hold: res_ready held low 20 cycles -> res_valid and result stable. A start pulse during HOLD is ignored (busy stays 1, no clr). res_ready=1 -> IDLE the next cycle.
- Reset mid-job: rst asserted in READ at j=3 -> the next cycle all outputs are 0 and state is IDLE. A new job with row = col = 1 (x6) -> result = 6, with no residue from the aborted job.
- Back-to-back jobs: a second job starts immediately after HOLD -> its result is independent of the first (clr verified).
